// File: rtl/freq_pkg.sv
// Shared definitions for the frequency counter configuration path.
package freq_pkg;

    // Period width shared by the counter and everything in front of it.
    localparam int unsigned FREQ_BITS = 12;

    // Counter and arbiter both reset to this window so their views agree.
    localparam int unsigned FREQ_RESET_PERIOD = 1200;

    // Smallest period that still gives the counter a usable window.
    localparam int unsigned FREQ_MIN_PERIOD = 16;

    // Default idle gap after each load pulse.
    localparam int unsigned FREQ_HOLDOFF = 4;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LOAD  = 2'd2,
        ST_HOLD  = 2'd3
    } freq_state_e;

endpackage : freq_pkg

// File: rtl/freq_period_arbiter_if.sv
// Requester handshakes plus the period/period_load path into the counter.
interface freq_period_arbiter_if
    import freq_pkg::*;
#(
    parameter int unsigned BITS = FREQ_BITS
) ();

    logic            req0_valid;
    logic [BITS-1:0] req0_period;
    logic            req0_ready;
    logic            req1_valid;
    logic [BITS-1:0] req1_period;
    logic            req1_ready;
    logic [BITS-1:0] period;
    logic            period_load;
    logic [BITS-1:0] cur_period;
    logic            grant_id;
    logic            clamped;

    // Arbiter side: consumes requests, drives the counter configuration.
    modport slave (
        input  req0_valid,
        input  req0_period,
        output req0_ready,
        input  req1_valid,
        input  req1_period,
        output req1_ready,
        output period,
        output period_load,
        output cur_period,
        output grant_id,
        output clamped
    );

    // Requester / observer side.
    modport master (
        output req0_valid,
        output req0_period,
        input  req0_ready,
        output req1_valid,
        output req1_period,
        input  req1_ready,
        input  period,
        input  period_load,
        input  cur_period,
        input  grant_id,
        input  clamped
    );

endinterface : freq_period_arbiter_if

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick; the last-grant history lives in the parent.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic any,
    output logic sel
);

    // On a tie, favour whichever requester was not served last.
    always_comb begin
        any = valid0 | valid1;
        if (valid0 && valid1) begin
            sel = ~last_grant;
        end else begin
            sel = valid1;
        end
    end

endmodule : rr_arbiter2

// File: rtl/freq_period_arbiter.sv
// Arbitrates two period requesters onto the counter's single load port,
// clamping short periods and spacing loads with a hold-off window.
module freq_period_arbiter
    import freq_pkg::*;
#(
    parameter int unsigned BITS         = FREQ_BITS,
    parameter int unsigned RESET_PERIOD = FREQ_RESET_PERIOD,
    parameter int unsigned MIN_PERIOD   = FREQ_MIN_PERIOD,
    parameter int unsigned HOLDOFF      = FREQ_HOLDOFF
) (
    input logic                 clk,
    input logic                 reset,
    freq_period_arbiter_if.slave bus
);

    localparam int unsigned   CNT_W     = $clog2(HOLDOFF + 1);
    localparam logic [BITS-1:0] MIN_P   = BITS'(MIN_PERIOD);
    localparam logic [BITS-1:0] RESET_P = BITS'(RESET_PERIOD);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLDOFF - 1);

    // Reject configurations that cannot be represented or never hold off.
    if (longint'(MIN_PERIOD) > longint'((64'd1 << BITS) - 64'd1)) begin : g_min_range
        $error("MIN_PERIOD does not fit in BITS");
    end
    if (HOLDOFF < 1) begin : g_holdoff_range
        $error("HOLDOFF must be at least 1");
    end

    freq_state_e      state;
    logic             sel_q;
    logic             last_grant;
    logic [BITS-1:0]  latched;
    logic             clamp_pending;
    logic [CNT_W-1:0] hold_cnt;

    logic             arb_any;
    logic             arb_sel;
    logic             sel_valid;
    logic [BITS-1:0]  sel_period;
    logic             sel_short;

    rr_arbiter2 u_rr (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant),
        .any        (arb_any),
        .sel        (arb_sel)
    );

    // Request currently chosen for the grant, and whether it needs clamping.
    always_comb begin
        sel_valid  = sel_q ? bus.req1_valid  : bus.req0_valid;
        sel_period = sel_q ? bus.req1_period : bus.req0_period;
        sel_short  = (sel_period < MIN_P);
    end

    // Sequencer: pick, grant (or abort), load once, then hold off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            sel_q           <= 1'b0;
            last_grant      <= 1'b1;
            latched         <= RESET_P;
            clamp_pending   <= 1'b0;
            hold_cnt        <= '0;
            bus.req0_ready  <= 1'b0;
            bus.req1_ready  <= 1'b0;
            bus.period_load <= 1'b0;
            bus.period      <= RESET_P;
            bus.cur_period  <= RESET_P;
            bus.grant_id    <= 1'b0;
            bus.clamped     <= 1'b0;
        end else begin
            bus.req0_ready  <= 1'b0;
            bus.req1_ready  <= 1'b0;
            bus.period_load <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        sel_q <= arb_sel;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A requester that withdrew is simply forgotten.
                    if (sel_valid) begin
                        bus.req0_ready <= ~sel_q;
                        bus.req1_ready <= sel_q;
                        latched        <= sel_short ? MIN_P : sel_period;
                        clamp_pending  <= sel_short;
                        last_grant     <= sel_q;
                        state          <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    bus.period_load <= 1'b1;
                    bus.period      <= latched;
                    bus.cur_period  <= latched;
                    bus.grant_id    <= sel_q;
                    bus.clamped     <= clamp_pending;
                    hold_cnt        <= HOLD_INIT;
                    state           <= ST_HOLD;
                end
                ST_HOLD: begin
                    // Keeps the counter's measurement window from being starved.
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : freq_period_arbiter

// File: tb/tb_freq_period_arbiter.sv
// Directed bench for freq_period_arbiter: vector table plus multi-cycle sequences.
module tb_freq_period_arbiter;
    import freq_pkg::*;

    localparam int unsigned BITS = 12;
    localparam logic [11:0] RP   = 12'd1200;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    freq_period_arbiter_if #(.BITS(BITS)) bus ();

    freq_period_arbiter #(
        .BITS         (BITS),
        .RESET_PERIOD (1200),
        .MIN_PERIOD   (16),
        .HOLDOFF      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // One clock of stimulus and the registered outputs expected after it.
    typedef struct {
        logic        rst;
        logic        v0;
        logic [11:0] p0;
        logic        v1;
        logic [11:0] p1;
        logic        r0;
        logic        r1;
        logic        ld;
        logic [11:0] per;
        logic        gid;
        logic        cl;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   passes = 0;

    task automatic add(input logic rst, input logic v0, input logic [11:0] p0,
                       input logic v1, input logic [11:0] p1,
                       input logic r0, input logic r1, input logic ld,
                       input logic [11:0] per, input logic gid, input logic cl);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.p0 = p0; v.v1 = v1; v.p1 = p1;
        v.r0 = r0; v.r1 = r1; v.ld = ld; v.per = per; v.gid = gid; v.cl = cl;
        vq.push_back(v);
    endtask

    task automatic idle(input int n, input logic [11:0] per, input logic gid, input logic cl);
        for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, 0, 0, 0, per, gid, cl);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Compares every output; period and cur_period must both equal per.
    task automatic check_all(input string name, input logic r0, input logic r1, input logic ld,
                             input logic [11:0] per, input logic gid, input logic cl);
        check(name,
              64'({bus.req0_ready, bus.req1_ready, bus.period_load, bus.period,
                   bus.cur_period, bus.grant_id, bus.clamped}),
              64'({r0, r1, ld, per, per, gid, cl}));
    endtask

    task automatic set_in(input logic rst, input logic v0, input logic [11:0] p0,
                          input logic v1, input logic [11:0] p1);
        reset           = rst;
        bus.req0_valid  = v0;
        bus.req0_period = p0;
        bus.req1_valid  = v1;
        bus.req1_period = p1;
    endtask

    int          nload;
    logic        exp_ld;
    logic [1:0]  exp_rdy;

    initial begin
        // Reset, single req0, then clamp and full-scale req1 arriving at HOLD end.
        add(1, 0, 0, 0, 0,       0, 0, 0, RP, 0, 0);
        add(1, 0, 0, 0, 0,       0, 0, 0, RP, 0, 0);
        add(0, 1, 500, 0, 0,     0, 0, 0, RP, 0, 0);
        add(0, 1, 500, 0, 0,     1, 0, 0, RP, 0, 0);
        add(0, 0, 0, 0, 0,       0, 0, 1, 12'd500, 0, 0);
        idle(3, 12'd500, 0, 0);
        add(0, 0, 0, 1, 5,       0, 0, 0, 12'd500, 0, 0);
        add(0, 0, 0, 1, 5,       0, 0, 0, 12'd500, 0, 0);
        add(0, 0, 0, 1, 5,       0, 1, 0, 12'd500, 0, 0);
        add(0, 0, 0, 0, 0,       0, 0, 1, 12'd16, 1, 1);
        idle(3, 12'd16, 1, 1);
        add(0, 0, 0, 1, 4095,    0, 0, 0, 12'd16, 1, 1);
        add(0, 0, 0, 1, 4095,    0, 0, 0, 12'd16, 1, 1);
        add(0, 0, 0, 1, 4095,    0, 1, 0, 12'd16, 1, 1);
        add(0, 0, 0, 0, 0,       0, 0, 1, 12'd4095, 1, 0);
        idle(4, 12'd4095, 1, 0);
        // req0 withdraws in its grant cycle; req1 then served normally.
        add(0, 1, 900, 0, 0,     0, 0, 0, 12'd4095, 1, 0);
        add(0, 0, 0, 0, 0,       0, 0, 0, 12'd4095, 1, 0);
        add(0, 0, 0, 1, 800,     0, 0, 0, 12'd4095, 1, 0);
        add(0, 0, 0, 1, 800,     0, 1, 0, 12'd4095, 1, 0);
        add(0, 0, 0, 0, 0,       0, 0, 1, 12'd800, 1, 0);
        idle(4, 12'd800, 1, 0);
        // Boundary around MIN_PERIOD: 15 clamps, 16 passes unchanged.
        add(0, 1, 15, 0, 0,      0, 0, 0, 12'd800, 1, 0);
        add(0, 1, 15, 0, 0,      1, 0, 0, 12'd800, 1, 0);
        add(0, 0, 0, 0, 0,       0, 0, 1, 12'd16, 0, 1);
        idle(4, 12'd16, 0, 1);
        add(0, 1, 16, 0, 0,      0, 0, 0, 12'd16, 0, 1);
        add(0, 1, 16, 0, 0,      1, 0, 0, 12'd16, 0, 1);
        add(0, 0, 0, 0, 0,       0, 0, 1, 12'd16, 0, 0);
        idle(4, 12'd16, 0, 0);
        // Tie after a req0 load: req1 wins; req0 waits through HOLD unserved.
        add(0, 1, 100, 1, 200,   0, 0, 0, 12'd16, 0, 0);
        add(0, 1, 100, 1, 200,   0, 1, 0, 12'd16, 0, 0);
        add(0, 1, 100, 0, 0,     0, 0, 1, 12'd200, 1, 0);
        for (int i = 0; i < 4; i++) add(0, 1, 100, 0, 0, 0, 0, 0, 12'd200, 1, 0);
        add(0, 1, 100, 0, 0,     0, 0, 0, 12'd200, 1, 0);
        add(0, 1, 100, 0, 0,     1, 0, 0, 12'd200, 1, 0);
        add(0, 0, 0, 0, 0,       0, 0, 1, 12'd100, 0, 0);
        idle(4, 12'd100, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            set_in(vq[i].rst, vq[i].v0, vq[i].p0, vq[i].v1, vq[i].p1);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vq[i].r0, vq[i].r1, vq[i].ld,
                      vq[i].per, vq[i].gid, vq[i].cl);
        end

        // Both requesters held valid from reset: alternate 300/700 every 7 cycles.
        set_in(1, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        set_in(0, 1, 300, 1, 700);
        nload = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            exp_ld  = (k >= 2) && ((k - 2) % 7 == 0);
            exp_rdy = 2'b00;
            if ((k >= 1) && ((k - 1) % 7 == 0)) exp_rdy = (((k - 1) / 7) % 2 == 0) ? 2'b10 : 2'b01;
            check($sformatf("alt_ld_c%0d", k), 64'(bus.period_load), 64'(exp_ld));
            check($sformatf("alt_rdy_c%0d", k), 64'({bus.req0_ready, bus.req1_ready}), 64'(exp_rdy));
            if (exp_ld) begin
                check($sformatf("alt_val%0d", nload), 64'(bus.period),
                      (nload % 2 == 0) ? 64'd300 : 64'd700);
                nload++;
            end
        end
        check("alt_count", 64'(nload), 64'd6);

        // Reset while the request sits in LOAD: the load must never appear.
        set_in(1, 0, 0, 0, 0);
        @(negedge clk);
        set_in(0, 1, 1000, 0, 0);
        @(negedge clk);
        check_all("rl_grant", 0, 0, 0, RP, 0, 0);
        @(negedge clk);
        check_all("rl_ready", 1, 0, 0, RP, 0, 0);
        set_in(1, 0, 0, 0, 0);
        @(negedge clk);
        check_all("rl_reset", 0, 0, 0, RP, 0, 0);
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("rl_after", 0, 0, 0, RP, 0, 0);
        set_in(0, 0, 0, 1, 2000);
        @(negedge clk);
        check_all("rl_new_grant", 0, 0, 0, RP, 0, 0);
        @(negedge clk);
        check_all("rl_new_ready", 0, 1, 0, RP, 0, 0);
        set_in(0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("rl_new_load", 0, 0, 1, 12'd2000, 1, 0);
        @(negedge clk);
        check_all("rl_new_hold", 0, 0, 0, 12'd2000, 1, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_freq_period_arbiter
